// File: rtl/teras_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : teras_pkg
//  Description : Shared register offsets, STATUS bit positions and helpers
//                for the teras Wishbone bridges.
//  Revision    : 1.0 - initial release
// ============================================================================
package teras_pkg;

  // Register offsets, decoded from wbs_adr_i[3:2]
  localparam logic [1:0] TR_ADDR_DATA   = 2'd0;
  localparam logic [1:0] TR_ADDR_STATUS = 2'd1;

  // STATUS bit positions
  localparam int TR_ST_EMPTY     = 0;
  localparam int TR_ST_FULL      = 1;
  localparam int TR_ST_UNDERFLOW = 2;
  localparam int TR_ST_LEVEL_LSB = 8;

  // Value returned by a DATA read on an empty FIFO
  localparam logic [31:0] TR_UNDERFLOW_DATA = 32'h0000_0000;

  // Assemble the STATUS word; every unlisted bit reads as zero
  function automatic logic [31:0] tr_status_word(input logic       empty,
                                                 input logic       full,
                                                 input logic       underflow,
                                                 input logic [7:0] level);
    logic [31:0] w;
    w = 32'h0;
    w[TR_ST_EMPTY]     = empty;
    w[TR_ST_FULL]      = full;
    w[TR_ST_UNDERFLOW] = underflow;
    w[TR_ST_LEVEL_LSB +: 8] = level;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/teras_result_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : teras_result_reader_if
//  Description : Result stream (rts/rtr/data) plus Wishbone slave bus seen
//                by the result reader.
//  Revision    : 1.0 - initial release
// ============================================================================
interface teras_result_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  rts_i;
  logic                  rtr_o;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  wbs_stb_i;
  logic                  wbs_cyc_i;
  logic                  wbs_we_i;
  logic [3:0]            wbs_sel_i;
  logic [31:0]           wbs_adr_i;
  logic [31:0]           wbs_dat_i;
  logic                  wbs_ack_o;
  logic [31:0]           wbs_dat_o;
  logic                  not_empty_o;

  // The reader block itself
  modport slave (
    input  rts_i, data_i, wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i,
           wbs_adr_i, wbs_dat_i,
    output rtr_o, wbs_ack_o, wbs_dat_o, not_empty_o
  );

  // Producer of results and Wishbone requests
  modport master (
    output rts_i, data_i, wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i,
           wbs_adr_i, wbs_dat_i,
    input  rtr_o, wbs_ack_o, wbs_dat_o, not_empty_o
  );
endinterface
`default_nettype wire

// File: rtl/teras_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : teras_sync_fifo
//  Description : Single-clock FIFO with flush, level, empty and full.
//                Read data is the combinational head entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module teras_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  input  wire logic                    push,
  input  wire logic                    pop,
  input  wire logic                    flush,
  input  wire logic [DATA_WIDTH-1:0]   wr_data,
  output logic      [DATA_WIDTH-1:0]   rd_data,
  output logic      [$clog2(DEPTH):0]  level,
  output logic                         empty,
  output logic                         full
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic                  w_do_push;
  logic                  w_do_pop;

  // Flush overrides both operations; pushes into a full FIFO are dropped
  assign w_do_push = push && !full  && !flush;
  assign w_do_pop  = pop  && !empty && !flush;

  assign empty   = (r_level == '0);
  assign full    = (r_level == LW'(DEPTH));
  assign level   = r_level;
  assign rd_data = r_mem[r_rd_ptr];

  // Storage array; no reset needed since reads are qualified by the level
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally at DEPTH; level tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= r_level + LW'(w_do_push) - LW'(w_do_pop);
    end
  end
endmodule
`default_nettype wire

// File: rtl/teras_result_reader.sv
`default_nettype none
// ============================================================================
//  Module      : teras_result_reader
//  Description : Drains the teras result stream into a FIFO and exposes it
//                to the management core as DATA/STATUS Wishbone registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module teras_result_reader
  import teras_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  teras_result_reader_if.slave  bus
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic                  w_valid;
  logic                  w_act;
  logic [1:0]            w_reg;
  logic                  w_rd_data;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_flush;
  logic                  w_clr_uf;
  logic [DATA_WIDTH-1:0] w_head;
  logic [LW-1:0]         w_level;
  logic [LW-1:0]         w_level_next;
  logic                  w_empty;
  logic                  w_full;
  logic [31:0]           w_rd_mux;
  logic                  w_unused;
  logic                  r_rtr;
  logic                  r_ack;
  logic [31:0]           r_dat;
  logic                  r_underflow;

  // A request is acted on once; the registered ack masks the held request
  assign w_valid   = bus.wbs_cyc_i && bus.wbs_stb_i;
  assign w_act     = w_valid && !r_ack;
  assign w_reg     = bus.wbs_adr_i[3:2];
  assign w_rd_data = w_act && !bus.wbs_we_i && (w_reg == TR_ADDR_DATA);
  assign w_pop     = w_rd_data && !w_empty;
  assign w_flush   = w_act && bus.wbs_we_i && (w_reg == TR_ADDR_STATUS) && bus.wbs_dat_i[0];
  assign w_clr_uf  = w_act && bus.wbs_we_i && (w_reg == TR_ADDR_STATUS) && bus.wbs_dat_i[2];
  assign w_push    = bus.rts_i && r_rtr;

  assign bus.rtr_o       = r_rtr;
  assign bus.wbs_ack_o   = r_ack;
  assign bus.wbs_dat_o   = r_dat;
  assign bus.not_empty_o = !w_empty;

  // Byte selects and undecoded address/data bits have no function
  assign w_unused = ^{bus.wbs_sel_i, bus.wbs_adr_i[31:4], bus.wbs_adr_i[1:0],
                      bus.wbs_dat_i[31:3], bus.wbs_dat_i[1]};

  teras_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (w_push),
    .pop     (w_pop),
    .flush   (w_flush),
    .wr_data (bus.data_i),
    .rd_data (w_head),
    .level   (w_level),
    .empty   (w_empty),
    .full    (w_full)
  );

  // Occupancy after this edge; a same-cycle pop cannot free space for rtr
  always_comb begin
    w_level_next = w_level;
    if (w_flush) w_level_next = '0;
    else         w_level_next = w_level + LW'(w_push) - LW'(w_pop);
  end

  // Read-data selection by register offset
  always_comb begin
    w_rd_mux = 32'h0;
    case (w_reg)
      TR_ADDR_DATA:   w_rd_mux = w_empty ? TR_UNDERFLOW_DATA : 32'(w_head);
      TR_ADDR_STATUS: w_rd_mux = tr_status_word(w_empty, w_full, r_underflow, 8'(w_level));
      default:        w_rd_mux = 32'h0;
    endcase
  end

  // Stream-ready, Wishbone response registers and sticky underflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rtr       <= 1'b0;
      r_ack       <= 1'b0;
      r_dat       <= 32'h0;
      r_underflow <= 1'b0;
    end else begin
      r_rtr <= (w_level_next < LW'(FIFO_DEPTH));
      r_ack <= w_act;
      if (w_act && !bus.wbs_we_i) r_dat <= w_rd_mux;
      if (w_rd_data && w_empty) r_underflow <= 1'b1;
      else if (w_clr_uf)        r_underflow <= 1'b0;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_teras_result_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_teras_result_reader
//  Description : Directed self-checking bench for teras_result_reader.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_teras_result_reader;
  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;

  teras_result_reader_if #(.DATA_WIDTH(32)) bus ();

  teras_result_reader #(
    .DATA_WIDTH (32),
    .FIFO_DEPTH (8)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Push one word; called and returns at a negedge
  task automatic push_word(input logic [31:0] w);
    int n;
    n = 0;
    bus.rts_i  = 1'b1;
    bus.data_i = w;
    while (bus.rtr_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("push_timeout", 32'(bus.rtr_o), 32'h1);
    @(posedge clk);
    @(negedge clk);
    bus.rts_i = 1'b0;
  endtask

  // One Wishbone transfer, optionally with a push on the request edge
  task automatic xfer(input string tag, input logic we, input logic [1:0] reg_sel,
                      input logic [31:0] wdata, input logic push_en,
                      input logic [31:0] push_data,
                      output logic [31:0] rdata, output logic rtr_s);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = {28'h0, reg_sel, 2'b00};
    bus.wbs_dat_i = wdata;
    if (push_en) begin
      bus.rts_i  = 1'b1;
      bus.data_i = push_data;
    end
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_ack"}, 32'(bus.wbs_ack_o), 32'h1);
    rdata = bus.wbs_dat_o;
    rtr_s = bus.rtr_o;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    if (push_en) bus.rts_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_ackdrop"}, 32'(bus.wbs_ack_o), 32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        rs;
    logic [31:0] q[$];
    logic [31:0] e;

    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    bus.rts_i     = 1'b0;
    bus.data_i    = '0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rtr", 32'(bus.rtr_o), 32'h0);
    chk("rst_ack", 32'(bus.wbs_ack_o), 32'h0);
    chk("rst_dat", bus.wbs_dat_o, 32'h0);
    chk("rst_ne", 32'(bus.not_empty_o), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rtr_after_rst", 32'(bus.rtr_o), 32'h1);

    // Basic push then read-back in order
    push_word(32'h1);
    chk("ne_after_push", 32'(bus.not_empty_o), 32'h1);
    push_word(32'h2);
    push_word(32'h3);
    xfer("rd1", 1'b0, 2'd0, 32'h0, 1'b0, 32'h0, rd, rs); chk("rd1", rd, 32'h1);
    xfer("rd2", 1'b0, 2'd0, 32'h0, 1'b0, 32'h0, rd, rs); chk("rd2", rd, 32'h2);
    xfer("rd3", 1'b0, 2'd0, 32'h0, 1'b0, 32'h0, rd, rs); chk("rd3", rd, 32'h3);
    xfer("st1", 1'b0, 2'd1, 32'h0, 1'b0, 32'h0, rd, rs); chk("st_empty", rd, 32'h0000_0001);

    // Fill to full, hold a ninth word, pop to release it
    for (int i = 0; i < 8; i++) push_word(32'h10 + 32'(i));
    chk("rtr_full", 32'(bus.rtr_o), 32'h0);
    bus.rts_i  = 1'b1;
    bus.data_i = 32'hAA;
    repeat (3) @(negedge clk);
    chk("rtr_hold", 32'(bus.rtr_o), 32'h0);
    xfer("stf", 1'b0, 2'd1, 32'h0, 1'b0, 32'h0, rd, rs); chk("st_full", rd, 32'h0000_0802);
    xfer("popf", 1'b0, 2'd0, 32'h0, 1'b0, 32'h0, rd, rs);
    chk("popf", rd, 32'h10);
    chk("rtr_after_pop", 32'(rs), 32'h1);
    bus.rts_i = 1'b0;
    xfer("st8", 1'b0, 2'd1, 32'h0, 1'b0, 32'h0, rd, rs); chk("st_level8", rd, 32'h0000_0802);
    for (int i = 0; i < 8; i++) begin
      e = (i == 7) ? 32'hAA : 32'h11 + 32'(i);
      xfer("drain", 1'b0, 2'd0, 32'h0, 1'b0, 32'h0, rd, rs);
      chk($sformatf("drain%0d", i), rd, e);
    end

    // Underflow and its clear
    xfer("uf", 1'b0, 2'd0, 32'h0, 1'b0, 32'h0, rd, rs); chk("uf_data", rd, 32'h0);
    xfer("st_uf", 1'b0, 2'd1, 32'h0, 1'b0, 32'h0, rd, rs); chk("st_uf", rd, 32'h0000_0005);
    xfer("clr", 1'b1, 2'd1, 32'h4, 1'b0, 32'h0, rd, rs);
    xfer("st_clr", 1'b0, 2'd1, 32'h0, 1'b0, 32'h0, rd, rs); chk("st_clr", rd, 32'h0000_0001);
    xfer("rsv", 1'b0, 2'd2, 32'h0, 1'b0, 32'h0, rd, rs); chk("rsv2", rd, 32'h0);

    // Simultaneous push and pop across pointer wrap
    for (int i = 0; i < 3; i++) begin
      push_word(32'h100 + 32'(i));
      q.push_back(32'h100 + 32'(i));
    end
    for (int k = 0; k < 20; k++) begin
      xfer("wrap", 1'b0, 2'd0, 32'h0, 1'b1, 32'h103 + 32'(k), rd, rs);
      q.push_back(32'h103 + 32'(k));
      e = q.pop_front();
      chk($sformatf("wrap%0d", k), rd, e);
    end
    xfer("st3", 1'b0, 2'd1, 32'h0, 1'b0, 32'h0, rd, rs); chk("st_level3", rd, 32'h0000_0300);

    // Flush wins over a same-edge push
    xfer("flush", 1'b1, 2'd1, 32'h1, 1'b1, 32'h55, rd, rs);
    chk("flush_ne", 32'(bus.not_empty_o), 32'h0);
    xfer("fl_rd", 1'b0, 2'd0, 32'h0, 1'b0, 32'h0, rd, rs); chk("flush_rd", rd, 32'h0);
    xfer("fl_st", 1'b0, 2'd1, 32'h0, 1'b0, 32'h0, rd, rs); chk("flush_st", rd, 32'h0000_0005);
    xfer("clr2", 1'b1, 2'd1, 32'h4, 1'b0, 32'h0, rd, rs);

    // Reset in the middle of a read
    for (int i = 0; i < 5; i++) push_word(32'h200 + 32'(i));
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_adr_i = 32'h0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_ack", 32'(bus.wbs_ack_o), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", 32'(bus.wbs_ack_o), 32'h0);
    chk("mid_rst_rtr", 32'(bus.rtr_o), 32'h0);
    chk("mid_rst_ne", 32'(bus.not_empty_o), 32'h0);
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xfer("st_rst", 1'b0, 2'd1, 32'h0, 1'b0, 32'h0, rd, rs); chk("st_after_rst", rd, 32'h0000_0001);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/teras_result_reader.md
# teras_result_reader

Drains the result stream produced on the teras master side (rts/rtr/data) into a small FIFO and makes it readable by the management core over Wishbone. It is the read-back counterpart of the Wishbone-to-teras input bridge: the bridge writes operands into teras, this block returns results to software. It sits between `teras.data_o`/`rts_o`/`rtr_i` and a Wishbone slave port.

## Interface
- `DATA_WIDTH`, 32: result word width; must be 32.
- `FIFO_DEPTH`, 8: FIFO entries; power of two, 2..128.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rts_i` in 1: teras result valid (teras `rts_o`).
- `rtr_o` out 1: ready to accept a result (teras `rtr_i`).
- `data_i` in DATA_WIDTH: result word (teras `data_o`).
- `wbs_stb_i` in 1: Wishbone strobe.
- `wbs_cyc_i` in 1: Wishbone cycle.
- `wbs_we_i` in 1: write enable.
- `wbs_sel_i` in 4: byte selects; ignored, full-word access only.
- `wbs_adr_i` in 32: address; only bits [3:2] decoded.
- `wbs_dat_i` in 32: write data.
- `wbs_ack_o` out 1: transfer acknowledge.
- `wbs_dat_o` out 32: read data.
- `not_empty_o` out 1: FIFO holds at least one word; intended for an IO pad or IRQ.

## Operation
- Stream push: a word is accepted on a cycle where `rts_i && rtr_o`. `rtr_o` is registered and equals "level after this cycle < FIFO_DEPTH".
- Register map, selected by `wbs_adr_i[3:2]`:
  - 0 DATA (R): pops the head word. Writes are acked and ignored.
  - 1 STATUS (R): bit0 empty, bit1 full, bit2 underflow (sticky), bits[15:8] level, all other bits 0.
  - 1 STATUS (W): bit0=1 flushes the FIFO; bit2=1 clears underflow.
  - 2, 3: read 0; writes are acked and ignored.
- A DATA read while empty returns 0x0000_0000, sets underflow and does not change the pointers.
- Wishbone: `valid = wbs_cyc_i && wbs_stb_i`. The block acts on `valid && !wbs_ack_o`: the pop or register access happens on that edge, and `wbs_ack_o` and `wbs_dat_o` are registered for one cycle. Back-to-back requests are served every other cycle.
- Simultaneous push and pop: level is unchanged and both take effect. A pop frees no space for the same cycle, because `rtr_o` is already registered.
- Flush together with push: flush wins, the pushed word is discarded, and the level becomes 0.
- Read together with push when the FIFO is empty: the read underflows. There is no bypass path.
- Pointers are log2(FIFO_DEPTH) bits wide and wrap naturally. Level is log2(FIFO_DEPTH)+1 bits wide.

## Timing
- Reset values: `rtr_o`=0, `wbs_ack_o`=0, `wbs_dat_o`=0, `not_empty_o`=0, level=0, underflow=0, pointers=0.
- First edge after `rst_n` rises: `rtr_o`=1.
- Push accepted at edge N: `not_empty_o`, level and STATUS update at N. A request sampled at edge N+1 returns that word.
- Read latency: request sampled at edge N; `wbs_ack_o`=1 and `wbs_dat_o` valid after N until edge N+1; ack drops after N+1.
- `wbs_dat_o` holds its value between acks.
- Full: the push filling the last entry at edge N makes `rtr_o`=0 after N. A pop at edge M gives `rtr_o`=1 after M.
- Reset asserted mid-transaction: all state clears immediately, and any pending ack is lost.

## Structure
- Shared package `teras_pkg`: register offsets (`TR_ADDR_DATA`, `TR_ADDR_STATUS`), STATUS bit indices, and the underflow read value constant.
- Sub-module `teras_sync_fifo` (parameters DATA_WIDTH, DEPTH; ports push/pop/flush, data, level, empty, full). It is reusable for the input side.
- The top level holds the Wishbone decode, the ack/data registers, the underflow flag and the `rtr_o` register.

## Test plan
- Reset release, then push 0x1, 0x2, 0x3. Three DATA reads return 0x1, 0x2, 0x3 with one-cycle ack each. STATUS then reads 0x0000_0001.
- Push 8 words with `rts_i` held high. `rtr_o` drops after the 8th acceptance, and a 9th word 0xAA is held by teras. One DATA read makes `rtr_o`=1 after the pop edge and 0xAA is accepted next. STATUS level ends at 8.
- DATA read on an empty FIFO returns 0, and STATUS reads 0x0000_0005. Write 0x4 to STATUS, then STATUS reads 0x0000_0001.
- Level 3 and a continuous push stream, with a DATA read on the same edge as a push: level stays 3 and FIFO order is preserved across pointer wrap for 20 words.
- Write 0x1 to STATUS with a simultaneous push of 0x55: level becomes 0, `not_empty_o`=0, and the next DATA read underflows.
- Assert `rst_n` low mid-read with level 5: `wbs_ack_o`, `rtr_o` and `not_empty_o` go to 0 at once. After release, STATUS reads 0x0000_0001.
